lcd_window_streamer: RTL and testbench
======================================

# lcd_window_streamer

APB master that feeds the NT35510 APB adapter. It takes a rectangular window command plus a stream of 24-bit pixels and sends the full NT35510 register sequence over APB: column address set (2A00h–2A03h), page address set (2B00h–2B03h), memory write (2C00h), then one data write per pixel. It sits between the pixel source (a frame fill or DMA engine) and the LCD APB adapter, so software does not need to issue one APB access per pixel.

## Interface
- BASE_ADDR, default 32'h0000_0000: APB base of the LCD adapter. Instructions go to BASE_ADDR+0, data goes to BASE_ADDR+4.
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  window command valid
- cmd_ready  out  1  high only in IDLE
- cmd_x0, cmd_x1, cmd_y0, cmd_y1  in  16 each  inclusive window corners
- pix_valid  in  1  pixel valid
- pix_ready  out  1  high only in PIX_FETCH
- pix_data  in  24  RGB pixel
- paddr  out  32  APB address
- psel, penable, pwrite  out  1 each  APB control
- pwdata  out  32  APB write data
- pready, pslverr  in  1 each  APB response
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a command finishes
- err  out  1  sticky; cleared when the next command is accepted

## Operation
- **States:** IDLE, SETUP, ACCESS, GAP, PIX_FETCH, FINISH.
- **Command accept (IDLE):** on cmd_valid & cmd_ready, latch the corners, clear err and set step=0.
  - Compute npix = (x1−x0+1)·(y1−y0+1) as 32-bit unsigned.
  - If x1<x0 or y1<y0: set err=1, go to FINISH, issue no APB traffic.
  - Otherwise go to SETUP.
- **Header steps 0..16** (instruction writes use paddr=BASE_ADDR, data writes use paddr=BASE_ADDR+4):
  - Even step 2k (k=0..7): instruction write, pwdata = {16'h0, R[k]}, where R = 2A00h, 2A01h, 2A02h, 2A03h, 2B00h, 2B01h, 2B02h, 2B03h.
  - Odd step 2k+1: data write, pwdata = {24'h0, P[k]}, where P = x0[15:8], x0[7:0], x1[15:8], x1[7:0], y0[15:8], y0[7:0], y1[15:8], y1[7:0].
  - Step 16: instruction write, pwdata = 32'h0000_2C00.
- **Pixel phase:** after step 16, the remaining count is npix.
  - PIX_FETCH: pix_ready=1. On pix_valid, latch pwdata = {8'h00, pix_data}, paddr = BASE_ADDR+4, go to SETUP.
- **APB transfer:**
  - SETUP: psel=1, penable=0, pwrite=1, for exactly one cycle.
  - ACCESS: psel=1, penable=1. Hold until pready=1. If pslverr=1 in the same cycle, set err=1 and continue the sequence.
  - GAP: psel=0, penable=0 for one cycle.
  - After GAP, go to the next header step, PIX_FETCH (if pixels remain), or FINISH (if none remain).
- **FINISH:** done=1 for one cycle, then return to IDLE.
- paddr and pwdata stay stable from SETUP through the end of ACCESS. pwrite is always 1; the block issues no reads.
- pready and pslverr are ignored outside ACCESS.

## Timing
- **Reset values:** state IDLE, psel/penable/pwrite=0, paddr=0, pwdata=0, done=0, err=0, busy=0, cmd_ready=1, pix_ready=0.
- **Reset mid-transfer:** asynchronous abort. All outputs return to reset values immediately and no done pulse is produced.
- **First transfer:** command accepted at cycle T, SETUP at T+1, ACCESS from T+2.
- **Per-transfer cost:** 3 + W cycles, where W is the number of ACCESS cycles with pready=0 (SETUP + at least one ACCESS + GAP).
- **Pixel transfers:** add 1 cycle for PIX_FETCH, plus any cycles pix_valid stays low. psel stays low while waiting for a pixel.
- **Total:** 17 header transfers + npix pixel transfers + 1 FINISH cycle.
  - Example, zero-wait slave with pix_valid held high: done asserts at T + 1 + 17·3 + npix·4.
- **Invalid window:** done at T+1 with err=1.
- **Back-to-back commands:** cmd_ready rises in the cycle after done, so the minimum gap between commands is 1 cycle.

## Test plan
- **1×1 window at (0,0):** zero-wait pready, pixel 0xABCDEF. Expect 18 transfers with exact paddr/pwdata, last = BASE+4 / 0x00ABCDEF, done at T+1+51+4=T+56, err=0.
- **Window (0x0123,0x0045)-(0x01DF,0x031F):** check all 16 header parameter bytes. Check npix = 189·731 = 138159, and count the data writes after 2C00h.
- **pix_valid low for 10 cycles mid-stream:** expect psel=0 throughout the wait and no lost or duplicated pixels.
- **Slave holding pready low for 50 cycles per access** (as the adapter does on reads): expect penable held, paddr/pwdata stable, one-cycle GAP each time, correct done timing.
- **pslverr=1 on step 5 / invalid window x1<x0:** expect err sticky with the sequence completing / no psel and done at T+1 with err=1. The next valid command clears err.
- **nrst asserted during ACCESS of pixel 3:** expect outputs at reset values immediately, no done. A new command afterwards restarts from step 0.

Source files
------------

// File: rtl/lcd_window_streamer.sv
// APB write master that streams a rectangular window into the NT35510 LCD adapter:
// column/page address set, memory write, then one data write per incoming pixel.
module lcd_window_streamer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_x0,
    input  logic [15:0] cmd_x1,
    input  logic [15:0] cmd_y0,
    input  logic [15:0] cmd_y1,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_data,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETUP     = 3'd1;
    localparam logic [2:0] S_ACCESS    = 3'd2;
    localparam logic [2:0] S_GAP       = 3'd3;
    localparam logic [2:0] S_PIX_FETCH = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;

    // Steps 0..15 are address-set pairs, 16 is memory write, 17 marks the pixel phase.
    localparam logic [4:0] STEP_MEMWR = 5'd16;
    localparam logic [4:0] STEP_PIX   = 5'd17;

    logic [2:0]  state_q, state_d;
    logic [4:0]  step_q, step_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        err_q, err_d;
    logic [15:0] x0_q, x1_q, y0_q, y1_q;

    logic [16:0] win_w, win_h;
    logic [31:0] npix;
    logic        win_bad;
    logic [31:0] rem_after;

    // Header word for a given step: even steps carry the register index, odd steps one parameter byte.
    function automatic logic [31:0] header_word(input logic [4:0] step,
                                                input logic [15:0] x0, input logic [15:0] x1,
                                                input logic [15:0] y0, input logic [15:0] y1);
        logic [31:0] word;
        logic [15:0] corner;
        case (step[3:2])
            2'd0:    corner = x0;
            2'd1:    corner = x1;
            2'd2:    corner = y0;
            default: corner = y1;
        endcase
        if (step == STEP_MEMWR)
            word = 32'h0000_2C00;
        else if (!step[0])
            word = {16'h0000, (step[3] ? 8'h2B : 8'h2A), 6'h00, step[2:1]};
        else
            word = {24'h00_0000, (step[1] ? corner[7:0] : corner[15:8])};
        return word;
    endfunction

    assign win_w   = {1'b0, cmd_x1} - {1'b0, cmd_x0} + 17'd1;
    assign win_h   = {1'b0, cmd_y1} - {1'b0, cmd_y0} + 17'd1;
    assign npix    = {15'd0, win_w} * {15'd0, win_h};
    assign win_bad = (cmd_x1 < cmd_x0) || (cmd_y1 < cmd_y0);

    // cmd and pix handshakes fire on the rising edge where valid and ready are both high;
    // ready depends only on state, never combinationally on valid.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        rem_d     = rem_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        err_d     = err_q;
        rem_after = (step_q == STEP_PIX) ? rem_q - 32'd1 : rem_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    err_d  = 1'b0;
                    step_d = 5'd0;
                    rem_d  = npix;
                    if (win_bad) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        paddr_d  = BASE_ADDR;
                        pwdata_d = header_word(5'd0, cmd_x0, cmd_x1, cmd_y0, cmd_y1);
                        state_d  = S_SETUP;
                    end
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    state_d = S_GAP;
                    if (pslverr) err_d = 1'b1;
                end
            end
            S_GAP: begin
                if (step_q < STEP_MEMWR) begin
                    step_d   = step_q + 5'd1;
                    paddr_d  = step_q[0] ? BASE_ADDR : BASE_ADDR + 32'd4;
                    pwdata_d = header_word(step_q + 5'd1, x0_q, x1_q, y0_q, y1_q);
                    state_d  = S_SETUP;
                end else begin
                    // Count a pixel only once its write has completed.
                    rem_d   = rem_after;
                    step_d  = STEP_PIX;
                    state_d = (rem_after != 32'd0) ? S_PIX_FETCH : S_FINISH;
                end
            end
            S_PIX_FETCH: begin
                if (pix_valid) begin
                    paddr_d  = BASE_ADDR + 32'd4;
                    pwdata_d = {8'h00, pix_data};
                    state_d  = S_SETUP;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            step_q   <= 5'd0;
            rem_q    <= 32'd0;
            paddr_q  <= 32'd0;
            pwdata_q <= 32'd0;
            err_q    <= 1'b0;
            x0_q     <= 16'd0;
            x1_q     <= 16'd0;
            y0_q     <= 16'd0;
            y1_q     <= 16'd0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            rem_q    <= rem_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            err_q    <= err_d;
            if (state_q == S_IDLE && cmd_valid) begin
                x0_q <= cmd_x0;
                x1_q <= cmd_x1;
                y0_q <= cmd_y0;
                y1_q <= cmd_y1;
            end
        end
    end

    assign psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable   = (state_q == S_ACCESS);
    assign pwrite    = psel;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign pix_ready = (state_q == S_PIX_FETCH);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign err       = err_q;

endmodule

// File: tb/tb_lcd_window_streamer.sv
// Bench for lcd_window_streamer: a window/pixel model builds the expected APB write list,
// a negedge process plays the APB slave and pixel source and checks every completed transfer.
module tb_lcd_window_streamer;
    localparam logic [31:0] BASE = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_x0 = '0, cmd_x1 = '0, cmd_y0 = '0, cmd_y1 = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [23:0] pix_data = '0;
    logic [31:0] paddr, pwdata;
    logic        psel, penable, pwrite;
    logic        pready = 1'b0, pslverr = 1'b0;
    logic        busy, done, err;

    lcd_window_streamer #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [63:0] exp_q[$];
    logic [23:0] pix_src_q[$];

    int wait_cfg = 0, err_idx = -1, acc_cnt = 0, xfer_n = 0;
    int stall_at = -1, stall_left = 0, popped = 0;
    int t_accept = 0, exp_done_cyc = -1, exp_npix = 0, pix_writes = 0;
    bit active = 0, exp_err = 0, fire_pending = 0, prev_completed = 0, after_2c = 0;
    logic [63:0] hold_xfer = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic int model_npix(input int x0, input int x1, input int y0, input int y1);
        return (x1 - x0 + 1) * (y1 - y0 + 1);
    endfunction

    // Expected APB write list: 8 register/parameter pairs, memory write, then the pixels.
    task automatic build_expected(input logic [15:0] x0, input logic [15:0] x1,
                                  input logic [15:0] y0, input logic [15:0] y1,
                                  input int npush, input logic [23:0] pbase);
        logic [15:0] corners[4];
        logic [15:0] reg_idx;
        logic [7:0]  b;
        logic [23:0] p;
        corners[0] = x0; corners[1] = x1; corners[2] = y0; corners[3] = y1;
        for (int k = 0; k < 8; k++) begin
            reg_idx = ((k < 4) ? 16'h2A00 : 16'h2B00) + 16'(k % 4);
            b = (k % 2 == 0) ? corners[k / 2][15:8] : corners[k / 2][7:0];
            exp_q.push_back({BASE, 16'h0000, reg_idx});
            exp_q.push_back({BASE + 32'd4, 24'h00_0000, b});
        end
        exp_q.push_back({BASE, 32'h0000_2C00});
        for (int i = 0; i < npush; i++) begin
            p = pbase + 24'(i * 37);
            pix_src_q.push_back(p);
            exp_q.push_back({BASE + 32'd4, 8'h00, p});
        end
    endtask

    always @(negedge clk) begin
        if (!nrst) begin
            pready = 1'b0; pslverr = 1'b0; pix_valid = 1'b0;
            acc_cnt = 0; fire_pending = 0; prev_completed = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                t_accept = cyc; active = 1; xfer_n = 0; pix_writes = 0; after_2c = 0;
            end
            check("penable_needs_psel", 64'(penable && !psel), 64'(0));
            check("pwrite_with_psel", 64'(pwrite), 64'(psel));
            check("busy_vs_cmd_ready", 64'(busy), 64'(!cmd_ready));
            check("psel_low_while_fetching", 64'(pix_ready && psel), 64'(0));
            if (prev_completed) check("gap_after_access", 64'(psel), 64'(0));
            prev_completed = 0;
            if (done) begin
                if (!active) check("spurious_done", 64'(done), 64'(0));
                else begin
                    if (exp_done_cyc >= 0)
                        check("done_time", 64'(cyc - t_accept), 64'(exp_done_cyc));
                    check("err_at_done", 64'(err), 64'(exp_err));
                    check("leftover_transfers", 64'(exp_q.size()), 64'(0));
                    check("pixel_write_count", 64'(pix_writes), 64'(exp_npix));
                    active = 0;
                end
            end
            if (psel && !penable) hold_xfer = {paddr, pwdata};
            if (psel && penable) check("stable_in_access", {paddr, pwdata}, hold_xfer);
            if (psel && penable) begin
                if (acc_cnt == wait_cfg) begin
                    pready = 1'b1;
                    pslverr = (xfer_n == err_idx);
                    if (exp_q.size() == 0) check("unexpected_transfer", {paddr, pwdata}, 64'(0));
                    else check($sformatf("xfer_%0d", xfer_n), {paddr, pwdata}, exp_q.pop_front());
                    if (paddr == BASE && pwdata == 32'h0000_2C00) after_2c = 1;
                    else if (after_2c && paddr == BASE + 32'd4) pix_writes++;
                    xfer_n++;
                    prev_completed = 1;
                end else begin
                    pready = 1'b0; pslverr = 1'b0;
                end
                acc_cnt++;
            end else begin
                pready = 1'b0; pslverr = 1'b0; acc_cnt = 0;
            end
            if (fire_pending && pix_src_q.size() > 0) begin
                void'(pix_src_q.pop_front());
                popped++;
            end
            if (popped == stall_at && stall_left > 0) begin
                pix_valid = 1'b0;
                stall_left--;
            end else if (pix_src_q.size() > 0) begin
                pix_valid = 1'b1;
                pix_data = pix_src_q[0];
            end else begin
                pix_valid = 1'b0;
            end
            fire_pending = pix_valid && pix_ready;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"}, 64'(psel), 64'(0));
        check({tag, "_penable"}, 64'(penable), 64'(0));
        check({tag, "_pwrite"}, 64'(pwrite), 64'(0));
        check({tag, "_paddr"}, 64'(paddr), 64'(0));
        check({tag, "_pwdata"}, 64'(pwdata), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_pix_ready"}, 64'(pix_ready), 64'(0));
    endtask

    task automatic prepare_window(input logic [15:0] x0, input logic [15:0] x1,
                                  input logic [15:0] y0, input logic [15:0] y1,
                                  input int npush, input logic [23:0] pbase,
                                  input int w, input int eidx, input int stall, input bit timed);
        bit bad;
        bad = (x1 < x0) || (y1 < y0);
        wait_cfg = w; err_idx = eidx; stall_at = stall; stall_left = (stall >= 0) ? 10 : 0;
        popped = 0;
        exp_q.delete();
        pix_src_q.delete();
        if (!bad) build_expected(x0, x1, y0, y1, npush, pbase);
        exp_npix = bad ? 0 : model_npix(int'(x0), int'(x1), int'(y0), int'(y1));
        exp_err = bad || (eidx >= 0);
        exp_done_cyc = bad ? 1 : (timed ? 1 + 17 * (3 + w) + exp_npix * (4 + w) : -1);
    endtask

    task automatic send_cmd(input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] y0, input logic [15:0] y1);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (cmd_ready) begin ok = 1; break; end
        end
        check("cmd_ready_wait", 64'(ok), 64'(1));
        cmd_x0 = x0; cmd_x1 = x1; cmd_y0 = y0; cmd_y1 = y1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_accepted", 64'(active), 64'(1));
        if (!((x1 < x0) || (y1 < y0))) begin
            check("err_cleared_on_accept", 64'(err), 64'(0));
            check("setup_at_t_plus_1", 64'({psel, penable}), 64'(2'b10));
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!active) break;
            @(posedge clk); #1;
        end
        if (active) begin
            check("done_timeout", 64'(active), 64'(0));
            nrst = 1'b0; #1; nrst = 1'b1;
            active = 0;
        end
    endtask

    task automatic run_window(input logic [15:0] x0, input logic [15:0] x1,
                              input logic [15:0] y0, input logic [15:0] y1,
                              input logic [23:0] pbase, input int w, input int eidx,
                              input int stall, input bit timed);
        int n;
        n = ((x1 < x0) || (y1 < y0)) ? 0 : model_npix(int'(x0), int'(x1), int'(y0), int'(y1));
        prepare_window(x0, x1, y0, y1, n, pbase, w, eidx, stall, timed);
        send_cmd(x0, x1, y0, y1);
        wait_done(5000);
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        nrst = 1'b1;
        repeat (2) @(posedge clk);

        // 1x1 at origin, zero-wait slave.
        prepare_window(16'h0, 16'h0, 16'h0, 16'h0, 1, 24'hABCDEF, 0, -1, -1, 1);
        check("model_1x1_count", 64'(exp_q.size()), 64'(18));
        check("model_1x1_last", exp_q[17], {BASE + 32'd4, 32'h00AB_CDEF});
        check("model_1x1_done", 64'(exp_done_cyc), 64'(56));
        send_cmd(16'h0, 16'h0, 16'h0, 16'h0);
        wait_done(5000);

        // 5x3 window, counts every data write after the memory-write command.
        run_window(16'h0002, 16'h0006, 16'h0003, 16'h0005, 24'h102030, 0, -1, -1, 1);

        // pix_valid low for 10 cycles after two pixels.
        run_window(16'h0010, 16'h0013, 16'h0010, 16'h0010, 24'h5A5A5A, 0, -1, 2, 0);

        // Slave stretching every access by 50 wait states.
        run_window(16'h0100, 16'h0100, 16'h0200, 16'h0200, 24'h123456, 50, -1, -1, 1);

        // Slave error on step 5: sequence completes, err sticky.
        run_window(16'h0001, 16'h0002, 16'h0001, 16'h0001, 24'h0F0F0F, 0, 5, -1, 1);

        // Invalid window: no APB traffic, done at T+1 with err.
        run_window(16'h0005, 16'h0004, 16'h0000, 16'h0000, 24'h0, 0, -1, -1, 1);

        // Next valid command clears err.
        run_window(16'h0007, 16'h0007, 16'h0009, 16'h0009, 24'hC0FFEE, 0, -1, -1, 1);

        // Large window: check the header bytes, then reset during pixel 3's access.
        prepare_window(16'h0123, 16'h01DF, 16'h0045, 16'h031F, 4, 24'h777777, 2, -1, -1, 0);
        check("model_npix_big", 64'(exp_npix), 64'(138159));
        check("model_hdr_x0_hi", exp_q[1], {BASE + 32'd4, 32'h01});
        check("model_hdr_x0_lo", exp_q[3], {BASE + 32'd4, 32'h23});
        check("model_hdr_x1_lo", exp_q[7], {BASE + 32'd4, 32'hDF});
        check("model_hdr_2b00", exp_q[8], {BASE, 32'h2B00});
        check("model_hdr_y0_lo", exp_q[11], {BASE + 32'd4, 32'h45});
        check("model_hdr_y1_hi", exp_q[13], {BASE + 32'd4, 32'h03});
        check("model_hdr_2c00", exp_q[16], {BASE, 32'h2C00});
        send_cmd(16'h0123, 16'h01DF, 16'h0045, 16'h031F);
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (xfer_n == 20 && psel && penable) begin found = 1; break; end
        end
        check("reached_pixel3_access", 64'(found), 64'(1));
        nrst = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        pix_src_q.delete();
        active = 0;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("after_abort");

        // Restart from step 0 after the abort.
        run_window(16'h0000, 16'h0000, 16'h0000, 16'h0000, 24'hABCDEF, 0, -1, -1, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
